axi_reg_responder: RTL and testbench
====================================

AXI_REG_RESPONDER -- requirements
Module: axi_reg_responder

Interface
REQ-001 Parameter RO_MASK, default 16'hF000, per-register flag; bit i=1 makes register i read-only status.
REQ-002 Parameter RST_VAL, default 32'h0000_0000, reset value of every writable register.
REQ-003 Port ps_aclk  in  1  sole clock; all logic rising-edge.
REQ-004 Port ps_aresetn  in  1  asynchronous, active-low reset.
REQ-005 Port s_axi_lite  AXI-lite register interface (TYPE_IF_AXI_REG), responder side, with the signal groups listed in REQ-006 to REQ-010.
REQ-006 AW group: axi_awaddr in 8, axi_awprot in 3, axi_awvalid in 1, axi_awready out 1.
REQ-007 W group: axi_wdata in 32, axi_wstrb in 4, axi_wvalid in 1, axi_wready out 1.
REQ-008 B group: axi_bresp out 2, axi_bvalid out 1, axi_bready in 1.
REQ-009 AR group: axi_araddr in 8, axi_arprot in 3, axi_arvalid in 1, axi_arready out 1.
REQ-010 R group: axi_rdata out 32, axi_rresp out 2, axi_rvalid out 1, axi_rready in 1.
REQ-011 Port reg_o  out  16x32 (512)  current contents of registers 0..15, register i at bits [32i+31:32i].
REQ-012 Port status_i  in  16x32 (512)  read value for read-only registers, same packing.
REQ-013 Port wr_pulse_o  out  16  one-cycle strobe per register on a committed write.

Function
REQ-014 Register index is addr[5:2]; addr[7:6] (bank bits) and addr[1:0] are ignored; AWPROT and ARPROT are ignored.
REQ-015 Write FSM states are IDLE, HAVE_AW, HAVE_W, COMMIT and RESP.
REQ-016 In IDLE, awready=1 and wready=1.
REQ-017 An AW-only handshake moves to HAVE_AW (awready=0, wready=1); a W-only handshake moves to HAVE_W (wready=0, awready=1); both in the same cycle move directly to COMMIT.
REQ-018 Address and data/strobe are captured on their own handshakes, so arrival order is free.
REQ-019 COMMIT lasts one cycle: writable register bytes are updated per wstrb, the wr_pulse_o bit for that register is set, and the FSM moves to RESP.
REQ-020 A wstrb of 4'b0000 still commits, changes no data, and still pulses.
REQ-021 In RESP, bvalid=1 with bresp=2'b00 (OKAY) for writable targets and 2'b10 (SLVERR) for read-only targets.
REQ-022 A write to a read-only target changes no register and produces no pulse.
REQ-023 bvalid holds with a stable bresp until bready; the handshake returns the FSM to IDLE, so the next AW can be accepted one cycle after the B handshake.
REQ-024 Write latency: handshake completing edge E0 -> reg_o updated and wr_pulse_o high after E1 -> bvalid high after E2.
REQ-025 Read path is independent of write: arready=1 whenever rvalid=0.
REQ-026 On an AR handshake at edge E0, rvalid=1 and rdata/rresp are registered at E0, giving one-cycle latency.
REQ-027 rdata is reg_o word for writable indices and status_i word for read-only indices, sampled at E0; rresp=2'b00.
REQ-028 rvalid, rdata and rresp hold stable until rready; arready=0 while rvalid=1.
REQ-029 Simultaneous COMMIT and AR capture to the same index returns the pre-write value.
REQ-030 Read-only entries of reg_o output status_i.

Reset
REQ-031 While ps_aresetn=0, asynchronously: write FSM in IDLE, awready=wready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, wr_pulse_o=0, writable registers=RST_VAL.
REQ-032 Reset mid-transaction discards the pending write (no commit, no response) and any pending read response.

Structure
REQ-033 The write FSM state enum and the BRESP/RRESP codes (OKAY=2'b00, SLVERR=2'b10) live in the shared qick package; no sub-module is used, and read/write channels are separate always_ff blocks.

Verification
REQ-034 AW(0x08) and W(0xDEADBEEF, strb F) in the same cycle -> reg_o[2]=0xDEADBEEF after E1, wr_pulse_o=0x0004 for one cycle, bvalid after E2 with bresp=00.
REQ-035 W (0x12345678, strb 4'b0011) three cycles before AW(0x04) with reg1=0xAAAAAAAA -> reg1=0xAAAA5678, single pulse on bit 1.
REQ-036 Write 0x3C with RO_MASK=F000 -> reg15 unchanged, wr_pulse_o=0, bresp=10; read 0x3C with status_i word 15=0xCAFE0001 -> rdata=0xCAFE0001.
REQ-037 bready held low 5 cycles -> bvalid and bresp stable and awready=0 throughout; the next AW is accepted one cycle after the B handshake.
REQ-038 AR(0xC8) with rready low 3 cycles -> rdata=reg2 value, arready=0 until the R handshake; the same-cycle COMMIT to reg2 returns the old value.
REQ-039 ps_aresetn pulsed low while in HAVE_AW -> immediately bvalid=0 and all registers=RST_VAL; a following full write completes normally.

Source files
------------

// File: rtl/axi_reg_responder_pkg.sv
// Shared types for the AXI-lite register responder.
// Latency: n/a (types, constants and a byte-merge helper only).
// Backpressure: n/a.
package axi_reg_responder_pkg;

  localparam int NUM_REGS = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  // Replace only the byte lanes enabled in strb.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_reg_responder.sv
// AXI-lite responder for 16 x 32-bit registers; RO_MASK entries mirror status_i.
// Latency: write handshake E0 -> reg/pulse after E1 -> bvalid after E2; read data one cycle after AR.
// Backpressure: bvalid/rvalid hold until bready/rready; AW/W and AR stall while a response is pending.
//
// Ports: ps_aclk/ps_aresetn clock and async active-low reset; axi_aw*/axi_w*/axi_b* write
// channels; axi_ar*/axi_r* read channels; reg_o packed register contents (word i at
// [32i+31:32i]); status_i packed read-only values; wr_pulse_o per-register commit strobe.
module axi_reg_responder
  import axi_reg_responder_pkg::*;
#(
  parameter logic [15:0] RO_MASK = 16'hF000,
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic         ps_aclk,
  input  logic         ps_aresetn,
  input  logic [7:0]   axi_awaddr,
  input  logic [2:0]   axi_awprot,
  input  logic         axi_awvalid,
  output logic         axi_awready,
  input  logic [31:0]  axi_wdata,
  input  logic [3:0]   axi_wstrb,
  input  logic         axi_wvalid,
  output logic         axi_wready,
  output logic [1:0]   axi_bresp,
  output logic         axi_bvalid,
  input  logic         axi_bready,
  input  logic [7:0]   axi_araddr,
  input  logic [2:0]   axi_arprot,
  input  logic         axi_arvalid,
  output logic         axi_arready,
  output logic [31:0]  axi_rdata,
  output logic [1:0]   axi_rresp,
  output logic         axi_rvalid,
  input  logic         axi_rready,
  output logic [511:0] reg_o,
  input  logic [511:0] status_i,
  output logic [15:0]  wr_pulse_o
);

  wr_state_t   r_wstate, w_wstate_nxt;
  logic [3:0]  r_widx;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [15:0] r_wr_pulse;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [31:0] w_words [NUM_REGS];
  logic        w_unused_ok;

  // Protection, bank bits, byte offset and status words of writable registers are don't-care.
  assign w_unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[7:6], axi_awaddr[1:0],
                         axi_araddr[7:6], axi_araddr[1:0], status_i};

  // ---------------- write FSM ----------------
  always_comb begin
    w_wstate_nxt = r_wstate;
    axi_awready  = 1'b0;
    axi_wready   = 1'b0;
    case (r_wstate)
      WR_IDLE: begin
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        if (axi_awvalid && axi_wvalid) w_wstate_nxt = WR_COMMIT;
        else if (axi_awvalid)          w_wstate_nxt = WR_HAVE_AW;
        else if (axi_wvalid)           w_wstate_nxt = WR_HAVE_W;
      end
      WR_HAVE_AW: begin
        axi_wready = 1'b1;
        if (axi_wvalid) w_wstate_nxt = WR_COMMIT;
      end
      WR_HAVE_W: begin
        axi_awready = 1'b1;
        if (axi_awvalid) w_wstate_nxt = WR_COMMIT;
      end
      WR_COMMIT: w_wstate_nxt = WR_RESP;
      WR_RESP: begin
        if (r_bvalid && axi_bready) w_wstate_nxt = WR_IDLE;
      end
      default: w_wstate_nxt = WR_IDLE;
    endcase
  end

  assign w_aw_hs  = axi_awvalid && axi_awready;
  assign w_w_hs   = axi_wvalid && axi_wready;
  assign w_commit = (r_wstate == WR_COMMIT);

  always_ff @(posedge ps_aclk or negedge ps_aresetn) begin
    if (!ps_aresetn) begin
      r_wstate   <= WR_IDLE;
      r_widx     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_wr_pulse <= '0;
      if (w_aw_hs) r_widx <= axi_awaddr[5:2];
      if (w_w_hs) begin
        r_wdata <= axi_wdata;
        r_wstrb <= axi_wstrb;
      end
      if (w_commit) begin
        r_bresp <= RO_MASK[r_widx] ? RESP_SLVERR : RESP_OKAY;
        if (!RO_MASK[r_widx]) r_wr_pulse[r_widx] <= 1'b1;
      end
      // The first RESP cycle only latches bvalid, so B trails the commit by one edge.
      if (r_wstate == WR_RESP && !r_bvalid) r_bvalid <= 1'b1;
      else if (r_bvalid && axi_bready)      r_bvalid <= 1'b0;
    end
  end

  assign axi_bvalid = r_bvalid;
  assign axi_bresp  = r_bresp;
  assign wr_pulse_o = r_wr_pulse;

  // ---------------- register file ----------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (RO_MASK[gi]) begin : g_ro
      assign reg_o[32*gi +: 32] = status_i[32*gi +: 32];
    end else begin : g_rw
      logic [31:0] r_val;
      always_ff @(posedge ps_aclk or negedge ps_aresetn) begin
        if (!ps_aresetn)                        r_val <= RST_VAL;
        else if (w_commit && r_widx == 4'(gi)) r_val <= apply_wstrb(r_val, r_wdata, r_wstrb);
      end
      assign reg_o[32*gi +: 32] = r_val;
    end
    assign w_words[gi] = reg_o[32*gi +: 32];
  end

  // ---------------- read channel ----------------
  assign axi_arready = !r_rvalid;
  assign w_ar_hs     = axi_arvalid && axi_arready;

  // reg_o already carries status_i for read-only words, and sampling the flops here
  // returns the pre-write value when a commit lands on the same edge.
  always_ff @(posedge ps_aclk or negedge ps_aresetn) begin
    if (!ps_aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_words[axi_araddr[5:2]];
      r_rresp  <= RESP_OKAY;
    end else if (r_rvalid && axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign axi_rvalid = r_rvalid;
  assign axi_rdata  = r_rdata;
  assign axi_rresp  = r_rresp;

endmodule

// File: tb/tb_axi_reg_responder.sv
// Directed bench for axi_reg_responder with B/R scoreboard queues.
// Latency: checks write E0/E1/E2 timing and one-cycle read latency.
// Backpressure: exercises held bready/rready and mid-transaction reset.
module tb_axi_reg_responder;

  logic         ps_aclk;
  logic         ps_aresetn;
  logic [7:0]   axi_awaddr;
  logic [2:0]   axi_awprot;
  logic         axi_awvalid;
  logic         axi_awready;
  logic [31:0]  axi_wdata;
  logic [3:0]   axi_wstrb;
  logic         axi_wvalid;
  logic         axi_wready;
  logic [1:0]   axi_bresp;
  logic         axi_bvalid;
  logic         axi_bready;
  logic [7:0]   axi_araddr;
  logic [2:0]   axi_arprot;
  logic         axi_arvalid;
  logic         axi_arready;
  logic [31:0]  axi_rdata;
  logic [1:0]   axi_rresp;
  logic         axi_rvalid;
  logic         axi_rready;
  logic [511:0] reg_o;
  logic [511:0] status_i;
  logic [15:0]  wr_pulse_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  axi_reg_responder dut (
    .ps_aclk(ps_aclk), .ps_aresetn(ps_aresetn),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
    .axi_rready(axi_rready),
    .reg_o(reg_o), .status_i(status_i), .wr_pulse_o(wr_pulse_o)
  );

  initial ps_aclk = 1'b0;
  always #5 ps_aclk = ~ps_aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return reg_o[32*i +: 32];
  endfunction

  task automatic tick();
    @(posedge ps_aclk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(axi_awready && axi_wready) && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Returns one step after the AW+W handshake edge (the COMMIT cycle).
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp);
    wait_idle();
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    bq.push_back(exp_resp);
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp_data);
    int k;
    k = 0;
    while (!axi_arready && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check("ar_wait_timeout", 32'd1, 32'd0);
    axi_araddr = a; axi_arvalid = 1'b1;
    rq.push_back({2'b00, exp_data});
    tick();
    axi_arvalid = 1'b0;
  endtask

  // Monitor: compares every B and R handshake against the queued expectations.
  initial begin
    logic [1:0]  eb;
    logic [33:0] er;
    forever begin
      @(negedge ps_aclk);
      if (ps_aresetn && axi_bvalid && axi_bready) begin
        if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else begin
          eb = bq.pop_front();
          check("bresp", {30'd0, axi_bresp}, {30'd0, eb});
        end
      end
      if (ps_aresetn && axi_rvalid && axi_rready) begin
        if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
        else begin
          er = rq.pop_front();
          check("rdata", axi_rdata, er[31:0]);
          check("rresp", {30'd0, axi_rresp}, {30'd0, er[33:32]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ps_aresetn = 1'b0;
    axi_awaddr = '0; axi_awprot = 3'b010; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
    axi_bready = 1'b1;
    axi_araddr = '0; axi_arprot = 3'b001; axi_arvalid = 1'b0;
    axi_rready = 1'b1;
    status_i = {512{1'b1}};
    status_i[32*15 +: 32] = 32'hCAFE_0001;
    status_i[32*14 +: 32] = 32'h1414_1414;
    status_i[32*12 +: 32] = 32'h1212_1212;

    // reset state
    #12;
    check("rst_awready", {31'd0, axi_awready}, 32'd1);
    check("rst_wready", {31'd0, axi_wready}, 32'd1);
    check("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    check("rst_resp", {28'd0, axi_bresp, axi_rresp}, 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    check("rst_pulse", {16'd0, wr_pulse_o}, 32'd0);
    check("rst_reg7", word(7), 32'd0);
    check("ro_passthru_14", word(14), 32'h1414_1414);
    @(negedge ps_aclk);
    ps_aresetn = 1'b1;
    tick();

    // simultaneous AW+W to reg2, latency E0/E1/E2
    do_write(8'h08, 32'hDEAD_BEEF, 4'hF, 2'b00);
    check("t1_pulse_e0", {16'd0, wr_pulse_o}, 32'd0);
    tick();
    check("t1_reg2_e1", word(2), 32'hDEAD_BEEF);
    check("t1_pulse_e1", {16'd0, wr_pulse_o}, 32'h0004);
    check("t1_bvalid_e1", {31'd0, axi_bvalid}, 32'd0);
    tick();
    check("t1_pulse_e2", {16'd0, wr_pulse_o}, 32'd0);
    check("t1_bvalid_e2", {31'd0, axi_bvalid}, 32'd1);
    tick();

    // W three cycles before AW, partial strobe
    do_write(8'h04, 32'hAAAA_AAAA, 4'hF, 2'b00);
    tick(); tick(); tick();
    wait_idle();
    axi_wdata = 32'h1234_5678; axi_wstrb = 4'b0011; axi_wvalid = 1'b1;
    tick();
    axi_wvalid = 1'b0;
    check("t2_have_w_wready", {31'd0, axi_wready}, 32'd0);
    check("t2_have_w_awready", {31'd0, axi_awready}, 32'd1);
    tick(); tick();
    check("t2_reg1_hold", word(1), 32'hAAAA_AAAA);
    check("t2_no_pulse_yet", {16'd0, wr_pulse_o}, 32'd0);
    axi_awaddr = 8'h04; axi_awvalid = 1'b1;
    bq.push_back(2'b00);
    tick();
    axi_awvalid = 1'b0;
    tick();
    check("t2_reg1", word(1), 32'hAAAA_5678);
    check("t2_pulse", {16'd0, wr_pulse_o}, 32'h0002);
    tick();
    check("t2_pulse_once", {16'd0, wr_pulse_o}, 32'd0);

    // read-only target
    do_write(8'h3C, 32'h1111_1111, 4'hF, 2'b10);
    tick();
    check("t3_ro_pulse", {16'd0, wr_pulse_o}, 32'd0);
    check("t3_reg15", word(15), 32'hCAFE_0001);
    do_read(8'h3C, 32'hCAFE_0001);

    // zero strobe still commits and pulses
    do_write(8'h00, 32'h0102_0304, 4'hF, 2'b00);
    do_write(8'h00, 32'hFFFF_FFFF, 4'h0, 2'b00);
    tick();
    check("t4_zero_strb_reg0", word(0), 32'h0102_0304);
    check("t4_zero_strb_pulse", {16'd0, wr_pulse_o}, 32'h0001);

    // bready held low 5 cycles
    wait_idle();
    axi_bready = 1'b0;
    do_write(8'h0C, 32'h0BAD_F00D, 4'hF, 2'b00);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("t5_bvalid_hold", {31'd0, axi_bvalid}, 32'd1);
      check("t5_bresp_hold", {30'd0, axi_bresp}, 32'd0);
      check("t5_awready_low", {31'd0, axi_awready}, 32'd0);
      tick();
    end
    axi_bready = 1'b1;
    tick();
    check("t5_bvalid_clear", {31'd0, axi_bvalid}, 32'd0);
    check("t5_aw_next_cycle", {31'd0, axi_awready}, 32'd1);
    do_write(8'h10, 32'h0000_0044, 4'hF, 2'b00);
    tick();
    check("t5_reg3", word(3), 32'h0BAD_F00D);
    check("t5_reg4", word(4), 32'h0000_0044);

    // AR to reg2 (bank bits set) on the same edge as its COMMIT
    wait_idle();
    axi_awaddr = 8'h08; axi_wdata = 32'h5555_5555; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    bq.push_back(2'b00);
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    axi_rready = 1'b0;
    axi_araddr = 8'hC8; axi_arvalid = 1'b1;
    rq.push_back({2'b00, 32'hDEAD_BEEF});
    tick();
    axi_arvalid = 1'b0;
    check("t6_reg2_new", word(2), 32'h5555_5555);
    for (int i = 0; i < 3; i++) begin
      check("t6_rvalid_hold", {31'd0, axi_rvalid}, 32'd1);
      check("t6_arready_low", {31'd0, axi_arready}, 32'd0);
      check("t6_rdata_hold", axi_rdata, 32'hDEAD_BEEF);
      tick();
    end
    axi_rready = 1'b1;
    tick();
    check("t6_arready_back", {31'd0, axi_arready}, 32'd1);
    do_read(8'h08, 32'h5555_5555);

    // reset in HAVE_AW
    wait_idle();
    axi_awaddr = 8'h14; axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0;
    check("t7_have_aw_awready", {31'd0, axi_awready}, 32'd0);
    #2 ps_aresetn = 1'b0;
    #1;
    check("t7_rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
    check("t7_rst_awready", {31'd0, axi_awready}, 32'd1);
    check("t7_rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
    for (int i = 0; i < 12; i++) check("t7_rst_reg", word(i), 32'd0);
    @(negedge ps_aclk);
    ps_aresetn = 1'b1;
    tick();
    do_write(8'h14, 32'h5A5A_5A5A, 4'hF, 2'b00);
    tick();
    check("t7_reg5", word(5), 32'h5A5A_5A5A);
    check("t7_pulse", {16'd0, wr_pulse_o}, 32'h0020);
    wait_idle();
    repeat (4) tick();
    check("bq_drained", bq.size(), 32'd0);
    check("rq_drained", rq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
